// File: rtl/reg_dump_pkg.sv
// Shared definitions for the debug register read-out path: word and address
// widths, the dump FSM state encoding and the last-index helper.
package reg_dump_pkg;

    localparam int WORD_W  = 32;
    localparam int RADDR_W = 5;
    localparam int IDX_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALT = 2'd1,
        ST_LOAD = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    // Index of the final word in a dump: the PC slot when it is emitted,
    // otherwise the highest general register.
    function automatic logic [IDX_W-1:0] last_index(input int nreg, input bit dump_pc);
        return dump_pc ? IDX_W'(nreg) : IDX_W'(nreg - 1);
    endfunction

endpackage

// File: rtl/reg_dump.sv
// Debug read-out engine: halts the core, walks the register file read port and
// optionally the PC, and streams each word out tagged with its index.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int DUMP_PC = 1
) (
    input  logic               clk,
    input  logic               rstd,
    input  logic               start,
    output logic               halt_req,
    input  logic               halt_ack,
    output logic [RADDR_W-1:0] rf_raddr,
    input  logic [WORD_W-1:0]  rf_rdata,
    input  logic [WORD_W-1:0]  pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic [WORD_W-1:0]  out_data,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_IDX = last_index(NREG, DUMP_PC != 0);
    localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(NREG);

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [RADDR_W-1:0]  rf_raddr_reg, rf_raddr_next;
    logic                out_valid_reg, out_valid_next;
    logic [IDX_W-1:0]    out_idx_reg, out_idx_next;
    logic [WORD_W-1:0]   out_data_reg, out_data_next;
    logic                halt_req_reg, halt_req_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            rf_raddr_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_data_reg  <= '0;
            halt_req_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            rf_raddr_reg  <= rf_raddr_next;
            out_valid_reg <= out_valid_next;
            out_idx_reg   <= out_idx_next;
            out_data_reg  <= out_data_next;
            halt_req_reg  <= halt_req_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        rf_raddr_next  = rf_raddr_reg;
        out_valid_next = out_valid_reg;
        out_idx_next   = out_idx_reg;
        out_data_next  = out_data_reg;
        halt_req_next  = halt_req_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_HALT;
                    idx_next      = '0;
                    rf_raddr_next = '0;
                    halt_req_next = 1'b1;
                    busy_next     = 1'b1;
                end
            end
            ST_HALT: begin
                // Address is registered so it is settled on the read port in LOAD.
                rf_raddr_next = idx_reg[RADDR_W-1:0];
                if (halt_ack) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                out_data_next  = (DUMP_PC != 0 && idx_reg == PC_IDX) ? pc : rf_rdata;
                out_idx_next   = idx_reg;
                out_valid_next = 1'b1;
                state_next     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (idx_reg == LAST_IDX) begin
                        halt_req_next = 1'b0;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        idx_next      = idx_reg + IDX_W'(1);
                        rf_raddr_next = RADDR_W'(idx_reg + IDX_W'(1));
                        state_next    = ST_LOAD;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign halt_req  = halt_req_reg;
    assign rf_raddr  = rf_raddr_reg;
    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
